axi_rd_checker: RTL

Read-back checker downstream of the AXI master controller's user read port in the AXI memory test path. Tracks each read burst from `rd_start` to `rd_done` and compares every returned beat against the incrementing data pattern the test writer produced. Accumulates error and burst statistics and captures the first mismatch for debug. Purely observational: it never back-pressures the controller.

---
 rtl/axi_chk_pkg.sv | 16 +
 rtl/sat_counter.sv | 24 ++
 rtl/axi_rd_checker.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/axi_chk_pkg.sv
// Shared types and helpers for the AXI read-back checker.
// Holds the FSM encoding, counter width default and beat sizing.
package axi_chk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } chk_state_e;

    localparam int CNT_W_DEF = 16;

    function automatic int bytes_per_beat(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once full.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // count up on inc, stick at all-ones, clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/axi_rd_checker.sv
// Read-back checker for the AXI memory test path.
// Compares returned beats with an incrementing pattern and keeps stats.
module axi_rd_checker
    import axi_chk_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] SEED   = '0,
    parameter int                CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_len,
    input  logic              rd_vld,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_done,
    output logic              busy,
    output logic              pass,
    output logic              err,
    output logic              len_err,
    output logic              seq_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  burst_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp
);

    localparam int BPB = bytes_per_beat(DATA_W);

    chk_state_e        state_q, state_n;
    logic [ADDR_W-1:0] base_q, base_n;
    logic [7:0]        len_q, len_n;
    logic [8:0]        idx_q, idx_n;
    logic [DATA_W-1:0] exp_q, exp_n;
    logic              derr_q, derr_n;
    logic              lerr_q, lerr_n;
    logic              serr_q, serr_n;
    logic              once_q, once_n;
    logic              err_n, pass_n;
    logic [CNT_W-1:0]  bcnt_q, bcnt_n;
    logic [ADDR_W-1:0] fa_q, fa_n;
    logic [DATA_W-1:0] fd_q, fd_n;
    logic [DATA_W-1:0] fe_q, fe_n;
    logic [ADDR_W-1:0] beat_addr;
    logic              mismatch;

    assign beat_addr = base_q + ADDR_W'(idx_q) * ADDR_W'(BPB);

    // next-state: beat check first, then burst close, then restart
    always_comb begin
        state_n  = state_q;
        base_n   = base_q;
        len_n    = len_q;
        idx_n    = idx_q;
        exp_n    = exp_q;
        derr_n   = derr_q;
        lerr_n   = lerr_q;
        serr_n   = serr_q;
        once_n   = once_q;
        bcnt_n   = bcnt_q;
        fa_n     = fa_q;
        fd_n     = fd_q;
        fe_n     = fe_q;
        mismatch = 1'b0;
        if (clr) begin
            state_n = IDLE;
            idx_n   = '0;
            exp_n   = SEED;
            derr_n  = 1'b0;
            lerr_n  = 1'b0;
            serr_n  = 1'b0;
            once_n  = 1'b0;
            bcnt_n  = '0;
            fa_n    = '0;
            fd_n    = '0;
            fe_n    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rd_vld || rd_done) begin
                        serr_n = 1'b1;
                    end
                    if (rd_start) begin
                        state_n = RECV;
                        base_n  = rd_addr;
                        len_n   = rd_len;
                        idx_n   = '0;
                    end
                end
                RECV: begin
                    if (rd_vld) begin
                        if (rd_data != exp_q) begin
                            mismatch = 1'b1;
                            derr_n   = 1'b1;
                            if (!derr_q) begin
                                fa_n = beat_addr;
                                fd_n = rd_data;
                                fe_n = exp_q;
                            end
                        end
                        exp_n = exp_q + DATA_W'(1);
                        idx_n = idx_q + 9'd1;
                    end
                    if (rd_done) begin
                        state_n = IDLE;
                        bcnt_n  = bcnt_q + CNT_W'(1);
                        once_n  = 1'b1;
                        if (idx_n != {1'b0, len_q}) begin
                            lerr_n = 1'b1;
                        end
                    end
                    if (rd_start) begin
                        if (!rd_done) begin
                            serr_n = 1'b1;
                        end
                        state_n = RECV;
                        base_n  = rd_addr;
                        len_n   = rd_len;
                        idx_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        err_n  = derr_n | lerr_n | serr_n;
        pass_n = once_n & ~err_n;
    end

    // state and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            exp_q   <= SEED;
            derr_q  <= 1'b0;
            lerr_q  <= 1'b0;
            serr_q  <= 1'b0;
            once_q  <= 1'b0;
            err     <= 1'b0;
            pass    <= 1'b0;
            bcnt_q  <= '0;
            fa_q    <= '0;
            fd_q    <= '0;
            fe_q    <= '0;
        end else begin
            state_q <= state_n;
            base_q  <= base_n;
            len_q   <= len_n;
            idx_q   <= idx_n;
            exp_q   <= exp_n;
            derr_q  <= derr_n;
            lerr_q  <= lerr_n;
            serr_q  <= serr_n;
            once_q  <= once_n;
            err     <= err_n;
            pass    <= pass_n;
            bcnt_q  <= bcnt_n;
            fa_q    <= fa_n;
            fd_q    <= fd_n;
            fe_q    <= fe_n;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .inc(mismatch),
        .cnt(err_cnt)
    );

    assign busy           = (state_q == RECV);
    assign len_err        = lerr_q;
    assign seq_err        = serr_q;
    assign burst_cnt      = bcnt_q;
    assign first_err_addr = fa_q;
    assign first_err_data = fd_q;
    assign first_err_exp  = fe_q;

endmodule
